// File: rtl/algoritmo_pkg.sv
// Shared encodings for the elevator floor-scheduling controller:
// motor command codes, controller states and travel direction.
package algoritmo_pkg;

  localparam logic [1:0] PARADO = 2'b00;
  localparam logic [1:0] SUBIR  = 2'b01;
  localparam logic [1:0] BAJAR  = 2'b10;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SUBIENDO = 2'd1,
    BAJANDO  = 2'd2,
    PUERTA   = 2'd3
  } estado_t;

  typedef enum logic {
    SUBE = 1'b0,
    BAJA = 1'b1
  } dir_t;

endpackage

// File: rtl/algoritmo_pisos_temporizador_puerta.sv
// Door dwell timer: load/reload to PUERTA_CICLOS-1, count down to zero.
module temporizador_puerta #(
  parameter int PUERTA_CICLOS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_cargar,
  input  logic i_decrementar,
  output logic o_cero
);

  localparam int TW = $clog2(PUERTA_CICLOS);

  logic [TW-1:0] r_cuenta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cuenta <= '0;
    end else if (i_cargar) begin
      r_cuenta <= TW'(PUERTA_CICLOS - 1);
    end else if (i_decrementar && (r_cuenta != '0)) begin
      r_cuenta <= r_cuenta - 1'b1;
    end
  end

  assign o_cero = (r_cuenta == '0);

endmodule

// File: rtl/algoritmo_pisos.sv
// Elevator scheduler: latches hall/car calls, chooses travel direction,
// stops at served floors and holds the door open for a timed dwell.
//
// state    | meaning
// REPOSO   | idle, motor stopped, door closed
// SUBIENDO | travelling up
// BAJANDO  | travelling down
// PUERTA   | stopped with door open, dwell timer running
module algoritmo_pisos
  import algoritmo_pkg::*;
#(
  parameter int N_PISOS       = 5,
  parameter int PUERTA_CICLOS = 8,
  parameter int PW            = $clog2(N_PISOS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_PISOS-1:0]     llamada_sub,
  input  logic [N_PISOS-1:0]     llamada_baj,
  input  logic [N_PISOS-1:0]     cabina,
  input  logic                   cambio_piso,
  input  logic                   esperar,
  output logic [1:0]             motor,
  output logic                   puerta_abierta,
  output logic [PW-1:0]          piso_actual,
  output logic [3*N_PISOS-1:0]   pendientes
);

  estado_t               r_estado, w_estado_nxt;
  dir_t                  r_dir, w_dir_nxt;
  logic [PW-1:0]         r_piso, w_piso_nxt, w_piso_up, w_piso_dn;
  logic [N_PISOS-1:0]    r_sub, r_baj, r_cab, w_pend, w_msk;
  logic [N_PISOS-1:0]    w_clr_sub, w_clr_baj, w_clr_cab;
  logic [1:0]            r_motor;
  logic                  r_puerta, w_entra, w_aqui, w_hold, w_cero;

  function automatic logic hay_arriba(input logic [N_PISOS-1:0] p, input logic [PW-1:0] f);
    hay_arriba = 1'b0;
    for (int i = 0; i < N_PISOS; i++)
      if (i > int'(f)) hay_arriba = hay_arriba | p[i];
  endfunction

  function automatic logic hay_abajo(input logic [N_PISOS-1:0] p, input logic [PW-1:0] f);
    hay_abajo = 1'b0;
    for (int i = 0; i < N_PISOS; i++)
      if (i < int'(f)) hay_abajo = hay_abajo | p[i];
  endfunction

  assign w_pend    = r_sub | r_baj | r_cab;
  assign w_piso_up = (r_piso == PW'(N_PISOS - 1)) ? r_piso : r_piso + 1'b1;
  assign w_piso_dn = (r_piso == '0) ? r_piso : r_piso - 1'b1;
  // A press at the open-door floor keeps the door open instead of being latched.
  assign w_aqui    = llamada_sub[r_piso] | llamada_baj[r_piso] | cabina[r_piso];
  assign w_hold    = (r_estado == PUERTA) & (esperar | w_aqui);

  always_comb begin
    w_estado_nxt = r_estado;
    w_dir_nxt    = r_dir;
    w_piso_nxt   = r_piso;
    w_entra      = 1'b0;
    case (r_estado)
      REPOSO: begin
        if (w_pend[r_piso]) begin
          w_estado_nxt = PUERTA;
          w_entra      = 1'b1;
        end else if (hay_arriba(w_pend, r_piso)) begin
          w_estado_nxt = SUBIENDO;
          w_dir_nxt    = SUBE;
        end else if (hay_abajo(w_pend, r_piso)) begin
          w_estado_nxt = BAJANDO;
          w_dir_nxt    = BAJA;
        end
      end
      SUBIENDO: begin
        if (cambio_piso) begin
          w_piso_nxt = w_piso_up;
          if (r_cab[w_piso_up] || r_sub[w_piso_up] ||
              (r_baj[w_piso_up] && !hay_arriba(w_pend, w_piso_up))) begin
            w_estado_nxt = PUERTA;
            w_entra      = 1'b1;
          end else if (!hay_arriba(w_pend, w_piso_up) || (w_piso_up == PW'(N_PISOS - 1))) begin
            w_estado_nxt = REPOSO;
          end
        end
      end
      BAJANDO: begin
        if (cambio_piso) begin
          w_piso_nxt = w_piso_dn;
          if (r_cab[w_piso_dn] || r_baj[w_piso_dn] ||
              (r_sub[w_piso_dn] && !hay_abajo(w_pend, w_piso_dn))) begin
            w_estado_nxt = PUERTA;
            w_entra      = 1'b1;
          end else if (!hay_abajo(w_pend, w_piso_dn) || (w_piso_dn == '0)) begin
            w_estado_nxt = REPOSO;
          end
        end
      end
      default: begin
        if (w_cero && !w_hold) begin
          if ((r_dir == SUBE) && hay_arriba(w_pend, r_piso)) begin
            w_estado_nxt = SUBIENDO;
          end else if (hay_abajo(w_pend, r_piso)) begin
            w_estado_nxt = BAJANDO;
            w_dir_nxt    = BAJA;
          end else if (hay_arriba(w_pend, r_piso)) begin
            w_estado_nxt = SUBIENDO;
            w_dir_nxt    = SUBE;
          end else begin
            w_estado_nxt = REPOSO;
          end
        end
      end
    endcase
  end

  always_comb begin
    w_msk     = '1;
    w_clr_sub = '0;
    w_clr_baj = '0;
    w_clr_cab = '0;
    if (r_estado == PUERTA) w_msk[r_piso] = 1'b0;
    // Hall calls are only cleared when the stop actually serves that direction.
    if (w_entra) begin
      w_clr_cab[w_piso_nxt] = 1'b1;
      w_clr_sub[w_piso_nxt] = (r_estado == REPOSO) || (r_dir == SUBE) ||
                              !hay_abajo(w_pend, w_piso_nxt);
      w_clr_baj[w_piso_nxt] = (r_estado == REPOSO) || (r_dir == BAJA) ||
                              !hay_arriba(w_pend, w_piso_nxt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= REPOSO;
      r_dir    <= SUBE;
      r_piso   <= '0;
      r_sub    <= '0;
      r_baj    <= '0;
      r_cab    <= '0;
      r_motor  <= PARADO;
      r_puerta <= 1'b0;
    end else begin
      r_estado <= w_estado_nxt;
      r_dir    <= w_dir_nxt;
      r_piso   <= w_piso_nxt;
      r_sub    <= (r_sub | (llamada_sub & w_msk)) & ~w_clr_sub;
      r_baj    <= (r_baj | (llamada_baj & w_msk)) & ~w_clr_baj;
      r_cab    <= (r_cab | (cabina & w_msk)) & ~w_clr_cab;
      case (w_estado_nxt)
        SUBIENDO: r_motor <= SUBIR;
        BAJANDO:  r_motor <= BAJAR;
        default:  r_motor <= PARADO;
      endcase
      r_puerta <= (w_estado_nxt == PUERTA);
    end
  end

  temporizador_puerta #(
    .PUERTA_CICLOS (PUERTA_CICLOS)
  ) u_temporizador (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cargar      (w_entra | w_hold),
    .i_decrementar ((r_estado == PUERTA) & ~w_hold),
    .o_cero        (w_cero)
  );

  assign motor          = r_motor;
  assign puerta_abierta = r_puerta;
  assign piso_actual    = r_piso;
  assign pendientes     = {r_cab, r_baj, r_sub};

endmodule

// File: doc/algoritmo_pisos.md
ALGORITMO_PISOS -- requirements
Module: algoritmo_pisos

Interface
REQ-001 The block SHALL have these parameters:
- N_PISOS, 5, number of floors (>= 2).
- PUERTA_CICLOS, 8, door-open dwell in clocks (>= 2).
- PW, $clog2(N_PISOS), floor-index width (min 1).

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- llamada_sub  in  N_PISOS  hall up-call pulses, one bit per floor.
- llamada_baj  in  N_PISOS  hall down-call pulses.
- cabina  in  N_PISOS  car-button pulses.
- cambio_piso  in  1  one-cycle pulse: car reached the next floor.
- esperar  in  1  door obstructed; hold door open.
- motor  out  2  00 parado, 01 subir, 10 bajar.
- puerta_abierta  out  1  door open command.
- piso_actual  out  PW  current floor index.
- pendientes  out  3*N_PISOS  {cab, baj, sub} pending registers.

REQ-003 Only one clock and one reset SHALL exist: clk, plus rst_n (asynchronous, active-low).

Function
REQ-004 All outputs SHALL be registered; motor SHALL never equal 11.

REQ-005 A request input bit high at an edge SHALL set the matching pending bit (OR-latch). This holds for any floor except the current floor while in PUERTA; there the press is not latched and instead reloads the door timer.

REQ-006 The FSM SHALL have exactly four states: REPOSO (motor 00, door 0), SUBIENDO (01, 0), BAJANDO (10, 0) and PUERTA (00, 1). A direction register dir_q (SUBE/BAJA) SHALL record the last travel direction.

REQ-007 REPOSO priority SHALL be:
- any pending bit at piso_actual -> PUERTA;
- else any pending above -> SUBIENDO, dir_q=SUBE;
- else any pending below -> BAJANDO, dir_q=BAJA;
- else stay.

REQ-008 In SUBIENDO, on cambio_piso, piso_actual SHALL increment by 1, saturating at N_PISOS-1. Using the new floor f:
- -> PUERTA if cab[f] or sub[f] is pending, or baj[f] is pending with nothing pending above f;
- else -> REPOSO if nothing is pending above f or f==N_PISOS-1;
- else stay in SUBIENDO.

REQ-009 BAJANDO SHALL mirror REQ-008: decrement saturating at 0, with the roles of sub and baj swapped and "above" replaced by "below".

REQ-010 On entering PUERTA at floor f, the block SHALL clear cab[f]. It SHALL clear sub[f] if dir_q==SUBE or nothing is pending below, and clear baj[f] if dir_q==BAJA or nothing is pending above. In REPOSO entry, all three bits SHALL clear.

REQ-011 If a set and a clear hit the same pending bit in the same edge, the clear SHALL win.

REQ-012 Door timer behaviour:
- loaded with PUERTA_CICLOS-1 on PUERTA entry;
- decrements each clock while esperar=0;
- reloaded while esperar=1;
- PUERTA exits when the timer is 0 and esperar=0.
Unobstructed, puerta_abierta SHALL therefore be high for exactly PUERTA_CICLOS cycles.

REQ-013 On PUERTA exit:
- dir_q==SUBE and pending above -> SUBIENDO;
- else pending below -> BAJANDO (dir_q=BAJA);
- else pending above -> SUBIENDO (dir_q=SUBE);
- else -> REPOSO.

REQ-014 cambio_piso SHALL be ignored in REPOSO and PUERTA.

REQ-015 Latency: a request pulse sampled at edge k SHALL be visible on pendientes after edge k. The resulting state and motor change SHALL appear after edge k+1.

Reset
REQ-016 While rst_n=0, asynchronously:
- state=REPOSO, dir_q=SUBE;
- piso_actual=0, pendientes=0;
- motor=00, puerta_abierta=0, door timer=0.

REQ-017 Reset asserted mid-travel or with the door open SHALL discard all pending requests; no output glitch to 11 is allowed.

REQ-018 After rst_n deasserts, the first state evaluation SHALL occur on the first clk rising edge.

Structure
REQ-019 Package algoritmo_pkg SHALL hold:
- the motor encodings (PARADO, SUBIR, BAJAR);
- the FSM state enum;
- the dir_q enum.

REQ-020 The door timer (load/decrement/reload/zero flag, width $clog2(PUERTA_CICLOS)) SHALL be a sub-module named temporizador_puerta. Above/below/at-floor reductions SHALL be combinational logic inside algoritmo_pisos.

Verification
REQ-021 Use N_PISOS=5, PUERTA_CICLOS=4 and cover these directed scenarios:
- Idle at 0, cabina[0] pulse at edge 1 -> PUERTA from edge 2, puerta_abierta high 4 cycles, then REPOSO; pendientes=0.
- Idle at 0, cabina[3] -> motor=01; after 3 cambio_piso pulses, piso_actual=3, motor=00, PUERTA, cab[3] cleared.
- Going up from 0 with llamada_baj[2] and cabina[4] pending -> passes floor 2 without stopping, serves 4, then descends and stops at 2.
- esperar held 6 cycles during PUERTA -> door stays open 6+4 cycles after esperar drops, measured from first assertion.
- rst_n low while motor=10 at floor 2 -> motor=00, piso_actual=0, pendientes=0 immediately, without a clk edge.
- cambio_piso pulsed in REPOSO -> piso_actual unchanged; motor never observed as 11 in any test.
